mdiv_adr_gen: RTL and testbench

- Burst address composer; the inverse of the bank/offset address split.
- Takes a start position as (bank index, word-in-bank) plus a beat count.
- Emits one flat data-memory address per beat, computed as bank*12 + offset.
- Sits between the SMA controller's bank-indexed sequencer and the flat-addressed data-memory port.

---
 rtl/mdiv_adr_gen.sv | 146 ++++++++++++++
 tb/tb_mdiv_adr_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdiv_adr_gen.sv
`default_nettype none
// ============================================================================
// Module   : mdiv_adr_gen
// Purpose  : Burst address composer: (bank, word-in-bank, length) in,
//            one flat address per beat out (bank*DIV_NUM + off).
// Revision : 1.0 - initial release
// ============================================================================
module mdiv_adr_gen #(
   parameter int DIV_NUM = 12,
   parameter int ADR_W   = 9,
   parameter int Q_W     = 6,
   parameter int R_W     = 4,
   parameter int LEN_W   = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [Q_W-1:0]   cmd_bank,
   input  logic [R_W-1:0]   cmd_off,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ADR_W-1:0] out_adr,
   output logic [Q_W-1:0]   out_bank,
   output logic [R_W-1:0]   out_off,
   output logic             out_last,
   output logic             done,
   output logic             err
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [R_W-1:0]   c_off_last = R_W'(DIV_NUM - 1);
   localparam logic [ADR_W-1:0] c_adr_max  = {ADR_W{1'b1}};

   state_t             r_state;
   logic               r_ready;
   logic               r_valid;
   logic [ADR_W-1:0]   r_adr;
   logic [Q_W-1:0]     r_bank;
   logic [R_W-1:0]     r_off;
   logic [LEN_W-1:0]   r_rem;
   logic               r_last;
   logic               r_done;
   logic               r_err;

   logic [ADR_W:0]     w_bank_ext;
   logic [ADR_W:0]     w_start_adr;
   logic               w_start_ovf;

   // One extra bit so a start beyond the top of memory is detectable.
   assign w_bank_ext  = {{(ADR_W+1-Q_W){1'b0}}, cmd_bank};
   assign w_start_adr = (w_bank_ext << 3) + (w_bank_ext << 2)
                      + {{(ADR_W+1-R_W){1'b0}}, cmd_off};
   assign w_start_ovf = w_start_adr[ADR_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_adr   <= '0;
         r_bank  <= '0;
         r_off   <= '0;
         r_rem   <= '0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_off > c_off_last) begin
                     r_err  <= 1'b1;
                     r_done <= 1'b1;
                  end else if (cmd_len == '0) begin
                     r_done <= 1'b1;
                  end else if (w_start_ovf) begin
                     r_err  <= 1'b1;
                     r_done <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                     r_ready <= 1'b0;
                     r_valid <= 1'b1;
                     r_adr   <= w_start_adr[ADR_W-1:0];
                     r_bank  <= cmd_bank;
                     r_off   <= cmd_off;
                     r_rem   <= cmd_len;
                     r_last  <= (cmd_len == LEN_W'(1));
                  end
               end
            end
            S_RUN: begin
               if (r_valid && out_ready) begin
                  if (r_last) begin
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (r_adr == c_adr_max) begin
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                     r_valid <= 1'b0;
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                  end else begin
                     // Flat address just counts; bank/off carry alongside it.
                     r_adr <= r_adr + ADR_W'(1);
                     if (r_off == c_off_last) begin
                        r_off  <= '0;
                        r_bank <= r_bank + Q_W'(1);
                     end else begin
                        r_off <= r_off + R_W'(1);
                     end
                     r_rem  <= r_rem - LEN_W'(1);
                     r_last <= (r_rem == LEN_W'(2));
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign out_valid = r_valid;
   assign out_adr   = r_adr;
   assign out_bank  = r_bank;
   assign out_off   = r_off;
   assign out_last  = r_last;
   assign done      = r_done;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdiv_adr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdiv_adr_gen
// Purpose  : Self-checking bench for mdiv_adr_gen against a burst-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdiv_adr_gen;

   localparam int ADR_W = 9;
   localparam int Q_W   = 6;
   localparam int R_W   = 4;
   localparam int LEN_W = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [Q_W-1:0]   cmd_bank = '0;
   logic [R_W-1:0]   cmd_off = '0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ADR_W-1:0] out_adr;
   logic [Q_W-1:0]   out_bank;
   logic [R_W-1:0]   out_off;
   logic             out_last;
   logic             done;
   logic             err;

   always #5 clk = ~clk;

   mdiv_adr_gen #(
      .DIV_NUM(12), .ADR_W(ADR_W), .Q_W(Q_W), .R_W(R_W), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_bank(cmd_bank), .cmd_off(cmd_off), .cmd_len(cmd_len),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_adr(out_adr), .out_bank(out_bank), .out_off(out_off),
      .out_last(out_last), .done(done), .err(err)
   );

   typedef struct {
      int adr;
      int bank;
      int off;
      bit last;
   } beat_t;

   beat_t exp_beats[$];
   bit    exp_ends[$];
   int    cap_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    pat[5] = '{1, 0, 0, 1, 1};

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_cap_at(input string name, input int idx, input int exp);
      check(name, (idx < cap_q.size()) ? cap_q[idx] : -1, exp);
   endtask

   // Whole-burst expectation: flat addresses start..start+len-1, clipped at 511.
   task automatic model_push(input int b, input int o, input int l);
      int start;
      start = b * 12 + o;
      if (o >= 12) exp_ends.push_back(1'b1);
      else if (l == 0) exp_ends.push_back(1'b0);
      else if (start > 511) exp_ends.push_back(1'b1);
      else begin
         for (int i = 0; i < l; i++) begin
            beat_t bt;
            if (start + i > 511) break;
            bt.adr  = start + i;
            bt.bank = (start + i) / 12;
            bt.off  = (start + i) % 12;
            bt.last = (i == l - 1);
            exp_beats.push_back(bt);
         end
         exp_ends.push_back(start + l - 1 > 511);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            check("invariant", (out_adr == out_bank * 12 + out_off) && (out_off < 12), 1);
            if (exp_beats.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_beat: got adr %0d expected no beat", out_adr);
            end else begin
               check("beat_adr", out_adr, exp_beats[0].adr);
               check("beat_bank", out_bank, exp_beats[0].bank);
               check("beat_off", out_off, exp_beats[0].off);
               check("beat_last", out_last, exp_beats[0].last);
               if (out_ready) begin
                  cap_q.push_back(int'(out_adr));
                  void'(exp_beats.pop_front());
               end
            end
         end
         if (done) begin
            if (exp_ends.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
               check("done_err", err, exp_ends[0]);
               void'(exp_ends.pop_front());
            end
         end else if (err) begin
            check("err_without_done", err, 0);
         end
      end
   end

   // Called at posedge+1; returns at the accept edge +1.
   task automatic issue_cmd(input int b, input int o, input int l);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      cmd_bank  = Q_W'(b);
      cmd_off   = R_W'(o);
      cmd_len   = LEN_W'(l);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      model_push(b, o, l);
   endtask

   // mode 0: ready high, 1: random ready, 2: pattern table then high.
   task automatic wait_done(input int mode, output bit e);
      int  cyc = 0;
      bit  seen = 1'b0;
      e = 1'b0;
      while (cyc < 3000 && !seen) begin
         if (done) begin
            seen = 1'b1;
            e = err;
         end else begin
            case (mode)
               0: out_ready = 1'b1;
               1: out_ready = ($urandom_range(0, 3) != 0);
               default: out_ready = (cyc < 5) ? pat[cyc][0] : 1'b1;
            endcase
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!seen) check("done_timeout", 0, 1);
   endtask

   initial begin
      bit e;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_adr", out_adr, 0);
      check("rst_done_err", {done, err, out_last}, 0);
      rst = 1'b0;

      // Bank-boundary carry
      cap_q.delete();
      issue_cmd(2, 10, 4);
      wait_done(0, e);
      check("carry_count", cap_q.size(), 4);
      check_cap_at("carry_a0", 0, 34);
      check_cap_at("carry_a1", 1, 35);
      check_cap_at("carry_a2", 2, 36);
      check_cap_at("carry_a3", 3, 37);
      check("carry_err", e, 0);

      // Back-pressure
      cap_q.delete();
      issue_cmd(0, 0, 3);
      wait_done(2, e);
      check("bp_count", cap_q.size(), 3);
      check_cap_at("bp_a0", 0, 0);
      check_cap_at("bp_a1", 1, 1);
      check_cap_at("bp_a2", 2, 2);

      // Illegal commands
      cap_q.delete();
      issue_cmd(3, 12, 3);
      check("ill_off_valid", out_valid, 0);
      check("ill_off_done", done, 1);
      wait_done(0, e);
      check("ill_off_err", e, 1);
      issue_cmd(3, 5, 0);
      check("len0_valid", out_valid, 0);
      wait_done(0, e);
      check("len0_err", e, 0);
      check("ill_no_beats", cap_q.size(), 0);

      // Top-of-memory overflow
      cap_q.delete();
      issue_cmd(42, 6, 5);
      wait_done(0, e);
      check("ovf_count", cap_q.size(), 2);
      check_cap_at("ovf_a0", 0, 510);
      check_cap_at("ovf_a1", 1, 511);
      check("ovf_err", e, 1);
      check("ovf_valid", out_valid, 0);
      cap_q.delete();
      issue_cmd(43, 0, 3);
      wait_done(0, e);
      check("ovf_start_err", e, 1);
      check("ovf_start_beats", cap_q.size(), 0);

      // Reset mid-burst
      out_ready = 1'b1;
      issue_cmd(5, 0, 8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_adr", out_adr, 62);
      #1 rst = 1'b1;
      exp_beats.delete();
      exp_ends.delete();
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_fields", {out_adr, out_bank, out_off, out_last, done, err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("post_rst_ready", cmd_ready, 1);
      cap_q.delete();
      issue_cmd(1, 0, 1);
      check("single_adr", out_adr, 12);
      check("single_last", out_last, 1);
      wait_done(0, e);
      check("single_count", cap_q.size(), 1);
      check("single_err", e, 0);

      // Random sweep, back-to-back commands
      for (int k = 0; k < 1000; k++) begin
         int b, o, l;
         b = $urandom_range(0, 63);
         o = $urandom_range(0, 11);
         l = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 16);
         cap_q.delete();
         issue_cmd(b, o, l);
         wait_done(1, e);
         if (!e) check("sweep_count", cap_q.size(), l);
      end

      @(posedge clk); #1;
      check("left_beats", exp_beats.size(), 0);
      check("left_ends", exp_ends.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
